// File: rtl/quad_decoder.sv
// Quadrature receiver: synchronises and glitch-filters an A/B pair, decodes steps into a
// wrapping position, counts illegal double transitions and drives hold-stretched direction levels.
module quad_decoder #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned HOLD_CYC   = 22500
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             ce,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             clear,
    output logic [CNT_W-1:0] position,
    output logic             step,
    output logic             dir,
    output logic             error,
    output logic [7:0]       err_count,
    output logic             right_o,
    output logic             left_o
);
    localparam int unsigned FC_W  = 4;
    localparam int unsigned TMR_W = 16;

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [1:0]       s1, s2;
    logic [1:0]       filt, filt_nxt;
    logic [1:0]       filt_old, filt_old_nxt;
    logic [FC_W-1:0]  fc, fc_nxt, run;
    logic             upd, upd_nxt;
    logic             fwd, rev, bad;
    logic [TMR_W-1:0] rt, rt_nxt, lt, lt_nxt;

    // PRIME waits for a stable input before tracking; TRACK accepts a value held FILTER_LEN samples.
    always_comb begin
        state_nxt    = state;
        filt_nxt     = filt;
        filt_old_nxt = filt_old;
        fc_nxt       = fc;
        upd_nxt      = 1'b0;
        run          = '0;
        if (ce) begin
            case (state)
                ST_PRIME: begin
                    run      = (s2 == filt) ? fc + FC_W'(1) : FC_W'(1);
                    filt_nxt = s2;
                    if (32'(run) >= FILTER_LEN) begin
                        state_nxt = ST_TRACK;
                        fc_nxt    = '0;
                    end else begin
                        fc_nxt = run;
                    end
                end
                ST_TRACK: begin
                    if (s2 == filt) begin
                        fc_nxt = '0;
                    end else if (32'(fc) == FILTER_LEN - 1) begin
                        filt_nxt     = s2;
                        filt_old_nxt = filt;
                        fc_nxt       = '0;
                        upd_nxt      = 1'b1;
                    end else begin
                        fc_nxt = fc + FC_W'(1);
                    end
                end
                default: state_nxt = ST_PRIME;
            endcase
        end
    end

    // Classify the accepted {A,B} change; A leading B is forward.
    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        bad = 1'b0;
        if (upd) begin
            case ({filt_old, filt})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd = 1'b1;
                4'b0001, 4'b0111, 4'b1110, 4'b1000: rev = 1'b1;
                4'b0011, 4'b1100, 4'b1001, 4'b0110: bad = 1'b1;
                default: ;
            endcase
        end
    end

    // A step reloads its own timer and kills the opposite one, so both levels are never high.
    always_comb begin
        rt_nxt = rt;
        lt_nxt = lt;
        if (fwd) begin
            rt_nxt = TMR_W'(HOLD_CYC);
            lt_nxt = '0;
        end else if (rev) begin
            lt_nxt = TMR_W'(HOLD_CYC);
            rt_nxt = '0;
        end else if (ce) begin
            if (rt != '0) rt_nxt = rt - TMR_W'(1);
            if (lt != '0) lt_nxt = lt - TMR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            state     <= ST_PRIME;
            filt      <= '0;
            filt_old  <= '0;
            fc        <= '0;
            upd       <= 1'b0;
            position  <= '0;
            step      <= 1'b0;
            dir       <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
            rt        <= '0;
            lt        <= '0;
            right_o   <= 1'b0;
            left_o    <= 1'b0;
        end else begin
            s1       <= {quad_a, quad_b};
            s2       <= s1;
            state    <= state_nxt;
            filt     <= filt_nxt;
            filt_old <= filt_old_nxt;
            fc       <= fc_nxt;
            upd      <= upd_nxt;
            step     <= fwd | rev;
            error    <= bad;
            if (fwd)      dir <= 1'b1;
            else if (rev) dir <= 1'b0;
            // clear wins over a coincident step or error
            if (clear)    position <= '0;
            else if (fwd) position <= position + CNT_W'(1);
            else if (rev) position <= position - CNT_W'(1);
            if (clear)                           err_count <= '0;
            else if (bad && err_count != 8'hFF)  err_count <= err_count + 8'd1;
            rt      <= rt_nxt;
            lt      <= lt_nxt;
            right_o <= (rt_nxt != '0);
            left_o  <= (lt_nxt != '0);
        end
    end
endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus a randomized phase walk,
// every cycle compared against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_quad_decoder;
    localparam int unsigned FILTER_LEN = 4;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned HOLD_CYC   = 16;
    localparam int          MODV       = 1 << CNT_W;

    logic             CLK = 1'b0;
    logic             reset, ce, quad_a, quad_b, clear;
    logic [CNT_W-1:0] position;
    logic             step, dir, error;
    logic [7:0]       err_count;
    logic             right_o, left_o;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int          n_steps = 0;
    int          n_errs  = 0;
    logic        cur_a = 1'b0;
    logic        cur_b = 1'b0;

    // reference model state
    logic [1:0] m_s1, m_s2, m_filt, m_old, m_new;
    logic [1:0] m_hist[$];
    bit         m_track, m_pend, m_step, m_dir, m_err;
    int         m_pos, m_ec, m_rt, m_lt;

    quad_decoder #(.FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC)) dut (
        .CLK(CLK), .reset(reset), .ce(ce), .quad_a(quad_a), .quad_b(quad_b), .clear(clear),
        .position(position), .step(step), .dir(dir), .error(error), .err_count(err_count),
        .right_o(right_o), .left_o(left_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Position of {A,B} along the forward cycle 00,10,11,01.
    function automatic int phase_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] idx_ab(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_edge();
        int         delta;
        bit         acc, loaded, all_eq, none_eq;
        logic [1:0] smp;
        delta = 0; acc = 0; loaded = 0;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_filt = '0; m_old = '0; m_new = '0;
            m_track = 0; m_pend = 0; m_hist.delete();
            m_pos = 0; m_step = 0; m_dir = 0; m_err = 0; m_ec = 0; m_rt = 0; m_lt = 0;
            return;
        end
        m_step = 0; m_err = 0;
        if (m_pend) begin
            delta = (phase_idx(m_new) - phase_idx(m_old) + 4) % 4;
            if (delta == 1) begin
                m_step = 1; m_dir = 1; m_pos = (m_pos + 1) % MODV;
                m_rt = HOLD_CYC; m_lt = 0; loaded = 1;
            end else if (delta == 3) begin
                m_step = 1; m_dir = 0; m_pos = (m_pos + MODV - 1) % MODV;
                m_lt = HOLD_CYC; m_rt = 0; loaded = 1;
            end else if (delta == 2) begin
                m_err = 1;
                if (m_ec < 255) m_ec++;
            end
        end
        if (!loaded && ce) begin
            if (m_rt > 0) m_rt--;
            if (m_lt > 0) m_lt--;
        end
        if (clear) begin m_pos = 0; m_ec = 0; end
        if (ce) begin
            smp = m_s2;
            m_hist.push_back(smp);
            if (m_hist.size() > FILTER_LEN) void'(m_hist.pop_front());
            if (m_hist.size() == FILTER_LEN) begin
                all_eq = 1; none_eq = 1;
                foreach (m_hist[i]) begin
                    if (m_hist[i] != smp)    all_eq = 0;
                    if (m_hist[i] == m_filt) none_eq = 0;
                end
                if (!m_track && all_eq) begin
                    m_track = 1; m_filt = smp; m_hist.delete();
                end else if (m_track && none_eq) begin
                    acc = 1; m_old = m_filt; m_new = smp; m_filt = smp; m_hist.delete();
                end
            end
        end
        m_pend = acc;
        m_s2 = m_s1;
        m_s1 = {quad_a, quad_b};
    endtask

    task automatic compare_all();
        check("position",  32'(position),  32'(m_pos));
        check("step",      32'(step),      32'(m_step));
        check("dir",       32'(dir),       32'(m_dir));
        check("error",     32'(error),     32'(m_err));
        check("err_count", 32'(err_count), 32'(m_ec));
        check("right_o",   32'(right_o),   32'(m_rt != 0));
        check("left_o",    32'(left_o),    32'(m_lt != 0));
    endtask

    task automatic cyc(input logic a, input logic b);
        quad_a = a; quad_b = b; cur_a = a; cur_b = b;
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
        if (step === 1'b1)  n_steps++;
        if (error === 1'b1) n_errs++;
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        for (int i = 0; i < n; i++) cyc(ab[1], ab[0]);
    endtask

    initial begin
        int   k, hi, p, len, r, pos_save;
        logic [1:0] ab;
        bit   prev_r;
        reset = 1'b1; ce = 1'b1; clear = 1'b0; quad_a = 1'b1; quad_b = 1'b1;

        // reset values, then prime with 11 present at release
        hold(2'b11, 3);
        check("rst_position", 32'(position), 0);
        check("rst_outputs", 32'({step, dir, error, right_o, left_o}), 0);
        check("rst_err_count", 32'(err_count), 0);
        reset = 1'b0;
        n_steps = 0; n_errs = 0;
        hold(2'b11, 10);
        check("prime_steps", 32'(n_steps), 0);
        check("prime_errors", 32'(n_errs), 0);
        check("prime_position", 32'(position), 0);

        // re-prime at 00
        reset = 1'b1; hold(2'b00, 2); reset = 1'b0; hold(2'b00, 10);

        // forward sweep, two full cycles, first-step latency
        n_steps = 0; k = 0;
        do begin cyc(1'b1, 1'b0); k++; end while (step !== 1'b1 && k < 20);
        check("first_step_edge", 32'(k), 7);
        hold(2'b10, 8 - k);
        hold(2'b11, 8); hold(2'b01, 8); hold(2'b00, 8);
        hold(2'b10, 8); hold(2'b11, 8); hold(2'b01, 8); hold(2'b00, 8);
        check("fwd_steps", 32'(n_steps), 8);
        check("fwd_position", 32'(position), 8);
        check("fwd_dir", 32'(dir), 1);
        check("fwd_right", 32'(right_o), 1);
        check("fwd_left", 32'(left_o), 0);

        // reverse from zero with wrap
        clear = 1'b1; cyc(1'b0, 1'b0); clear = 1'b0;
        check("clear_position", 32'(position), 0);
        prev_r = right_o; k = 0;
        do begin prev_r = right_o; cyc(1'b0, 1'b1); k++; end while (step !== 1'b1 && k < 20);
        check("rev_prev_right", 32'(prev_r), 1);
        check("rev_left_rise", 32'(left_o), 1);
        check("rev_right_fall", 32'(right_o), 0);
        hold(2'b01, 8 - k); hold(2'b11, 8); hold(2'b10, 8);
        check("rev_position", 32'(position), 253);
        check("rev_dir", 32'(dir), 0);
        hold(2'b00, 8);

        // glitch shorter than the filter is ignored
        pos_save = int'(position); n_steps = 0; n_errs = 0;
        hold(2'b10, 3); hold(2'b00, 10);
        check("glitch_position", 32'(position), 32'(pos_save));
        check("glitch_steps", 32'(n_steps), 0);
        check("glitch_errors", 32'(n_errs), 0);
        check("glitch_dir", 32'(dir), 0);

        // illegal double transitions
        hold(2'b11, 8);
        check("err_pulses", 32'(n_errs), 1);
        check("err_count_one", 32'(err_count), 1);
        check("err_position", 32'(position), 32'(pos_save));
        for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 2'b00 : 2'b11, 8);
        check("err_count_sat", 32'(err_count), 255);

        // hold expiry with ce continuously high
        k = 0;
        do begin cyc(1'b0, 1'b1); k++; end while (step !== 1'b1 && k < 20);
        check("hold_step_seen", 32'(step), 1);
        hi = 1; k = 0;
        while (right_o === 1'b1 && k < 100) begin
            cyc(1'b0, 1'b1); k++;
            if (right_o === 1'b1) hi++;
        end
        check("hold_ce_full", 32'(hi), 16);

        // hold expiry with ce every other clock
        k = 0;
        do begin cyc(1'b0, 1'b0); k++; end while (step !== 1'b1 && k < 20);
        check("hold2_step_seen", 32'(step), 1);
        hi = 1; k = 0; ce = 1'b0;
        while (right_o === 1'b1 && k < 100) begin
            cyc(1'b0, 1'b0); k++; ce = ~ce;
            if (right_o === 1'b1) hi++;
        end
        ce = 1'b1;
        check("hold_ce_half", 32'(hi), 32);

        // clear colliding with a forward step at position 5
        clear = 1'b1; cyc(1'b0, 1'b0); clear = 1'b0;
        hold(2'b10, 8); hold(2'b11, 8); hold(2'b01, 8); hold(2'b00, 8); hold(2'b10, 8);
        check("pre_clear_position", 32'(position), 5);
        hold(2'b11, 6);
        clear = 1'b1; cyc(1'b1, 1'b1); clear = 1'b0;
        check("clr_step", 32'(step), 1);
        check("clr_position", 32'(position), 0);
        check("clr_dir", 32'(dir), 1);
        check("clr_err_count", 32'(err_count), 0);
        hold(2'b11, 4);

        // reset in the middle of a sweep
        hold(2'b01, 8); hold(2'b00, 5);
        reset = 1'b1; cyc(1'b0, 1'b0); reset = 1'b0;
        check("midrst_position", 32'(position), 0);
        check("midrst_outputs", 32'({step, dir, error, right_o, left_o}), 0);
        check("midrst_err_count", 32'(err_count), 0);
        hold(2'b00, 10);

        // randomized phase walk against the model
        for (int i = 0; i < 300; i++) begin
            p = phase_idx({cur_a, cur_b});
            r = int'($urandom_range(0, 9));
            if (r < 4)      p = p + 1;
            else if (r < 7) p = p + 3;
            else if (r < 8) p = p + 2;
            ab  = idx_ab(p);
            len = int'($urandom_range(1, 12));
            for (int j = 0; j < len; j++) begin
                ce    = ($urandom_range(0, 3) != 0);
                clear = ($urandom_range(0, 63) == 0);
                reset = ($urandom_range(0, 499) == 0);
                cyc(ab[1], ab[0]);
            end
        end
        ce = 1'b1; clear = 1'b0; reset = 1'b0;
        hold({cur_a, cur_b}, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
